inst_mem_sync: RTL and testbench

INST_MEM_SYNC -- requirements
Module: inst_mem_sync

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loader.sv | 78 +++++++
 rtl/inst_mem_sync.sv | 104 ++++++++++
 tb/tb_inst_mem_sync.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the byte-loadable instruction memory.
// Used by the loader FSM and the fetch datapath.
package imem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_e;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-serial program loader: IDLE/LOAD FSM, base capture and
// saturating byte counter; emits one memory write per accepted byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              byte_valid_i,
    input  logic              last_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic              busy_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] offs_q, offs_d;
    logic [ADDR_W:0]   count_q, count_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            offs_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            offs_q  <= offs_d;
            count_q <= count_d;
        end
    end

    // offs_q wraps freely so writes keep circling after count saturates
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        offs_d  = offs_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    base_d  = base_i;
                    offs_d  = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (byte_valid_i) begin
                    offs_d = offs_q + 1'b1;
                    if (count_q != DEPTH_C) begin
                        count_d = count_q + 1'b1;
                    end
                    if (last_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == LOAD);
        we_o    = busy_o && byte_valid_i && !reset_i;
        waddr_o = base_q + offs_q;
        count_o = count_q;
    end

endmodule

// File: rtl/inst_mem_sync.sv
// Byte-addressed instruction memory with 1-cycle big-endian word fetch,
// stall hold, misalignment flag and a byte-serial program loader.
module inst_mem_sync
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              instr_err,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_busy,
    output logic [ADDR_W:0]   load_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       rd_word;
    logic              accept;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = 8'h00;
        end
    end

    imem_loader #(
        .ADDR_W(ADDR_W)
    ) u_loader (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (load_start),
        .base_i      (load_base),
        .byte_valid_i(load_byte_valid),
        .last_i      (load_last),
        .we_o        (we),
        .waddr_o     (waddr),
        .busy_o      (load_busy),
        .count_o     (load_count)
    );

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= load_byte;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_word = {rd_word[23:0], mem_q[fetch_addr + ADDR_W'(i)]};
        end
    end

    assign fetch_ready = !load_busy;
    assign accept      = fetch_req && fetch_ready && !fetch_stall;

    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (!fetch_stall) begin
            valid_d = accept;
            if (accept) begin
                err_d   = misaligned(fetch_addr[1:0]);
                instr_d = err_d ? NOP : rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign instr_err   = err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Scoreboard bench for inst_mem_sync: directed loads and fetches,
// expected words queued at issue and checked by a monitor.
module tb_inst_mem_sync;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [8:0]  fetch_addr;
    logic        fetch_stall;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_err;
    logic        load_start;
    logic [8:0]  load_base;
    logic        load_byte_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_busy;
    logic [9:0]  load_count;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic acc_s  = 1'b0;
    logic stl_s  = 1'b0;
    logic rst_s  = 1'b1;
    logic rdy_n  = 1'b0;

    inst_mem_sync dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_stall    (fetch_stall),
        .fetch_ready    (fetch_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_err      (instr_err),
        .load_start     (load_start),
        .load_base      (load_base),
        .load_byte_valid(load_byte_valid),
        .load_byte      (load_byte),
        .load_last      (load_last),
        .load_busy      (load_busy),
        .load_count     (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Inputs are stable at posedge; fetch_ready is a registered output
    always @(posedge clk) begin
        acc_s = fetch_req && rdy_n && !fetch_stall && !reset;
        stl_s = fetch_stall && !reset;
        rst_s = reset;
    end

    always @(negedge clk) begin
        if (rst_s) begin
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_err", {31'b0, instr_err}, 32'd0);
        end else if (acc_s) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch got %h want none", instr);
            end else begin
                mon_e = q.pop_front();
                chk("valid", {31'b0, instr_valid}, 32'd1);
                chk("instr", instr, mon_e.instr);
                chk("err", {31'b0, instr_err}, {31'b0, mon_e.err});
            end
        end else if (!stl_s) begin
            chk("idle_valid", {31'b0, instr_valid}, 32'd0);
        end
        rdy_n = fetch_ready;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [8:0] a, input logic [31:0] ei,
                         input logic ee);
        q.push_back(exp_t'{ei, ee});
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    task automatic load4(input logic [8:0] base, input logic [31:0] w);
        load_start = 1'b1;
        load_base  = base;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_byte_valid = 1'b1;
            load_byte       = w[31-8*i -: 8];
            load_last       = (i == 3);
            tick();
        end
        load_byte_valid = 1'b0;
        load_last       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bv;
        reset           = 1'b1;
        fetch_req       = 1'b0;
        fetch_addr      = '0;
        fetch_stall     = 1'b0;
        load_start      = 1'b0;
        load_base       = '0;
        load_byte_valid = 1'b0;
        load_byte       = '0;
        load_last       = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'b0, load_busy}, 32'd0);
        chk("rst_count", {22'b0, load_count}, 32'd0);
        chk("rst_ready", {31'b0, fetch_ready}, 32'd1);
        reset = 1'b0;

        load4(9'd0, 32'h01F4_4820);
        chk("ld0_count", {22'b0, load_count}, 32'd4);
        chk("ld0_busy", {31'b0, load_busy}, 32'd0);
        fetch(9'd0, 32'h01F4_4820, 1'b0);

        load4(9'd4, 32'h1122_3344);
        fetch(9'd6, 32'h0, 1'b1);
        fetch(9'd4, 32'h1122_3344, 1'b0);
        fetch(9'd1, 32'h0, 1'b1);

        load4(9'd510, 32'hAABB_CCDD);
        fetch(9'd508, 32'h0000_AABB, 1'b0);
        fetch(9'd0, 32'hCCDD_4820, 1'b0);

        fetch_stall = 1'b1;
        fetch_req   = 1'b1;
        fetch_addr  = 9'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", instr, 32'hCCDD_4820);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        fetch_stall = 1'b0;
        fetch_req   = 1'b0;
        tick();

        load4(9'd8, 32'h5566_7788);
        q.push_back(exp_t'{32'h5566_7788, 1'b0});
        fetch_req  = 1'b1;
        fetch_addr = 9'd8;
        load_start = 1'b1;
        load_base  = 9'd8;
        tick();
        chk("ovl_busy", {31'b0, load_busy}, 32'd1);
        chk("ovl_ready", {31'b0, fetch_ready}, 32'd0);
        load_base       = 9'd100;
        load_byte_valid = 1'b1;
        load_byte       = 8'h99;
        tick();
        load_start      = 1'b0;
        load_byte_valid = 1'b0;
        load_last       = 1'b1;
        tick();
        chk("lastnv_busy", {31'b0, load_busy}, 32'd1);
        chk("restart_count", {22'b0, load_count}, 32'd1);
        load_last       = 1'b0;
        load_byte_valid = 1'b1;
        load_byte       = 8'hAA;
        tick();
        load_byte       = 8'hBB;
        tick();
        load_byte       = 8'hCC;
        load_last       = 1'b1;
        chk("ovl_ready2", {31'b0, fetch_ready}, 32'd0);
        tick();
        load_byte_valid = 1'b0;
        load_last       = 1'b0;
        chk("ovl_done_busy", {31'b0, load_busy}, 32'd0);
        chk("ovl_done_ready", {31'b0, fetch_ready}, 32'd1);
        chk("ovl_count", {22'b0, load_count}, 32'd4);
        q.push_back(exp_t'{32'h99AA_BBCC, 1'b0});
        tick();
        fetch_req = 1'b0;
        tick();

        load4(9'd16, 32'hE1E2_E3E4);
        load_start = 1'b1;
        load_base  = 9'd16;
        tick();
        load_start      = 1'b0;
        load_byte_valid = 1'b1;
        load_byte       = 8'h12;
        tick();
        load_byte       = 8'h34;
        tick();
        chk("abort_pre_count", {22'b0, load_count}, 32'd2);
        reset      = 1'b1;
        load_byte  = 8'h56;
        fetch_req  = 1'b1;
        fetch_addr = 9'd0;
        tick();
        reset           = 1'b0;
        load_byte_valid = 1'b0;
        fetch_req       = 1'b0;
        chk("abort_busy", {31'b0, load_busy}, 32'd0);
        chk("abort_count", {22'b0, load_count}, 32'd0);
        fetch(9'd16, 32'h1234_E3E4, 1'b0);

        load_start = 1'b1;
        load_base  = 9'd200;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 514; k++) begin
            if (k < 512) bv = k[7:0];
            else bv = 8'hF0 + 8'(k - 512);
            if (k == 512) begin
                chk("sat_count512", {22'b0, load_count}, 32'd512);
            end
            load_byte_valid = 1'b1;
            load_byte       = bv;
            load_last       = (k == 513);
            tick();
        end
        load_byte_valid = 1'b0;
        load_last       = 1'b0;
        chk("sat_count", {22'b0, load_count}, 32'd512);
        chk("sat_busy", {31'b0, load_busy}, 32'd0);
        fetch(9'd200, 32'hF0F1_0203, 1'b0);
        fetch(9'd0, 32'h3839_3A3B, 1'b0);
        tick();
        tick();
        chk("queue_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
